// File: rtl/image_window_ctrl_pkg.sv
// Shared constants and FSM encoding for the 3x3 window front end.
package image_window_ctrl_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned NUM_LINES = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned WIN_PIX   = 9;
  localparam int unsigned WIN_W     = WIN_PIX * PIX_W_DEF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_READ     = 2'd1;
  localparam state_t ST_LINE_END = 2'd2;

endpackage

// File: rtl/image_window_ctrl_line_buffer.sv
// One image line of pixel storage; reads three horizontally adjacent pixels at once.
module image_window_ctrl_line_buffer #(
  parameter int unsigned LINE_W = 512,
  parameter int unsigned PIX_W  = 8,
  localparam int unsigned PTR_W = $clog2(LINE_W)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic [PTR_W-1:0]   rd_ptr,
  output logic [3*PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [LINE_W];
  logic [PTR_W-1:0] rd_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p2;

  // rd_ptr never exceeds LINE_W-3, so p+2 stays inside the line
  assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
  assign rd_ptr_p2 = rd_ptr + PTR_W'(2);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = {mem[rd_ptr_p2], mem[rd_ptr_p1], mem[rd_ptr]};

endmodule

// File: rtl/image_window_ctrl.sv
// Raster pixel stream into four rotating line buffers, emitting one 3x3 window per cycle
// with backpressure and a per-line completion pulse.
module image_window_ctrl
  import image_window_ctrl_pkg::*;
#(
  parameter int unsigned LINE_W = 512,
  parameter int unsigned PIX_W  = PIX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [PIX_W-1:0]     in_pixel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [9*PIX_W-1:0]   out_window,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 line_done
);

  localparam int unsigned PTR_W    = $clog2(LINE_W);
  localparam int unsigned FILL_W   = $clog2(NUM_LINES * LINE_W + 1);
  localparam int unsigned ROW_W    = 3 * PIX_W;
  localparam int unsigned WIN_BITS = WIN_PIX * PIX_W;

  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(NUM_LINES * LINE_W);
  localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * LINE_W);
  localparam logic [FILL_W-1:0] FILL_LINE  = FILL_W'(LINE_W);
  localparam logic [PTR_W-1:0]  WR_LAST    = PTR_W'(LINE_W - 1);
  localparam logic [PTR_W-1:0]  RD_LAST    = PTR_W'(LINE_W - 3);

  state_t               state_q,      state_d;
  logic [PTR_W-1:0]     wr_ptr_q,     wr_ptr_d;
  logic [SEL_W-1:0]     wr_sel_q,     wr_sel_d;
  logic [PTR_W-1:0]     rd_ptr_q,     rd_ptr_d;
  logic [SEL_W-1:0]     rd_sel_q,     rd_sel_d;
  logic [FILL_W-1:0]    fill_cnt_q,   fill_cnt_d;
  logic                 issued_all_q, issued_all_d;
  logic                 in_ready_q,   in_ready_d;
  logic                 out_valid_q,  out_valid_d;
  logic [WIN_BITS-1:0]  out_window_q, out_window_d;
  logic                 line_done_q,  line_done_d;

  logic                 wr_fire;
  logic                 out_free;
  logic                 issue_c;
  logic                 complete_c;
  logic [SEL_W-1:0]     sel_mid;
  logic [SEL_W-1:0]     sel_bot;
  logic [ROW_W-1:0]     bank_rd [NUM_LINES];
  logic [WIN_BITS-1:0]  win_c;

  assign wr_fire  = in_valid && in_ready_q;
  assign out_free = !out_valid_q || out_ready;

  for (genvar b = 0; b < NUM_LINES; b++) begin : g_bank
    image_window_ctrl_line_buffer #(
      .LINE_W (LINE_W),
      .PIX_W  (PIX_W)
    ) u_line_buffer (
      .clk     (clk),
      .wr_en   (wr_fire && (wr_sel_q == SEL_W'(b))),
      .wr_ptr  (wr_ptr_q),
      .wr_data (in_pixel),
      .rd_ptr  (rd_ptr_q),
      .rd_data (bank_rd[b])
    );
  end

  // Oldest line (rd_sel) lands in the low bytes of the window
  assign sel_mid = rd_sel_q + SEL_W'(1);
  assign sel_bot = rd_sel_q + SEL_W'(2);
  assign win_c   = {bank_rd[sel_bot], bank_rd[sel_mid], bank_rd[rd_sel_q]};

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_sel_d     = wr_sel_q;
    rd_ptr_d     = rd_ptr_q;
    rd_sel_d     = rd_sel_q;
    issued_all_d = issued_all_q;
    line_done_d  = 1'b0;
    issue_c      = 1'b0;
    complete_c   = 1'b0;

    if (wr_fire) begin
      if (wr_ptr_q == WR_LAST) begin
        wr_ptr_d = '0;
        wr_sel_d = wr_sel_q + SEL_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (fill_cnt_q >= FILL_START) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!issued_all_q) begin
          if (out_free) begin
            issue_c = 1'b1;
            if (rd_ptr_q == RD_LAST) begin
              issued_all_d = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
          end
        end else if (out_free) begin
          // Last window of the line has left the output register: release the top bank
          complete_c   = 1'b1;
          issued_all_d = 1'b0;
          rd_ptr_d     = '0;
          rd_sel_d     = rd_sel_q + SEL_W'(1);
          line_done_d  = 1'b1;
          state_d      = ST_LINE_END;
        end
      end
      ST_LINE_END: begin
        state_d = (fill_cnt_q >= FILL_START) ? ST_READ : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    fill_cnt_d = fill_cnt_q + FILL_W'(wr_fire) - (complete_c ? FILL_LINE : '0);

    // Falls in the same cycle the buffers fill; rises one cycle after a full buffer drains
    in_ready_d = (fill_cnt_d != FILL_FULL) && (fill_cnt_q != FILL_FULL);

    out_valid_d  = issue_c ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_window_d = issue_c ? win_c : out_window_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      wr_sel_q     <= '0;
      rd_ptr_q     <= '0;
      rd_sel_q     <= '0;
      fill_cnt_q   <= '0;
      issued_all_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      line_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_sel_q     <= wr_sel_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_sel_q     <= rd_sel_d;
      fill_cnt_q   <= fill_cnt_d;
      issued_all_q <= issued_all_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      line_done_q  <= line_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign line_done  = line_done_q;

endmodule

// File: tb/tb_image_window_ctrl.sv
// Scoreboard bench for image_window_ctrl with LINE_W=8: directed raster streams,
// backpressure, buffer-full and mid-line reset scenarios.
module tb_image_window_ctrl;

  localparam int unsigned LINE_W = 8;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned WIN_W  = 9 * PIX_W;
  localparam int unsigned WPL    = LINE_W - 2;

  localparam logic [WIN_W-1:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [WIN_W-1:0] STALL_WIN = 72'h24_23_22_14_13_12_04_03_02;
  localparam logic [WIN_W-1:0] POST_WIN  = 72'hA2_A1_A0_92_91_90_82_81_80;

  logic             clk = 1'b0;
  logic             rstn;
  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic [WIN_W-1:0] out_window;
  logic             out_valid;
  logic             out_ready;
  logic             line_done;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [WIN_W-1:0] exp_q [$];
  logic [7:0]       base = 8'h00;
  int               in_line = 0;
  logic             pend = 1'b0;

  always #5 clk = ~clk;

  image_window_ctrl #(
    .LINE_W (LINE_W),
    .PIX_W  (PIX_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_window (out_window),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .line_done  (line_done)
  );

  task automatic check(input string name, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected window for image line r (top row) at column c, pixel = base + row*16 + col
  function automatic logic [WIN_W-1:0] model_win(input int r, input int c);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int row = 0; row < 3; row++) begin
      for (int col = 0; col < 3; col++) begin
        w[(3*row+col)*PIX_W +: PIX_W] = 8'(int'(base) + (r + row) * 16 + c + col);
      end
    end
    return w;
  endfunction

  function automatic logic [7:0] pix(input int idx);
    return 8'(int'(base) + (idx / LINE_W) * 16 + (idx % LINE_W));
  endfunction

  task automatic push_line(input int r);
    for (int c = 0; c < int'(WPL); c++) exp_q.push_back(model_win(r, c));
  endtask

  // Called at a negedge; returns at the negedge after the transfer
  task automatic send_pixel(input logic [7:0] v);
    int g;
    in_pixel = v;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("in_ready_timeout", 72'(in_ready), 72'(1));
    @(negedge clk);
  endtask

  task automatic stream_row(input int r);
    for (int c = 0; c < int'(LINE_W); c++) send_pixel(pix(r * LINE_W + c));
    if (r >= 2) push_line(r - 2);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_first(input string name, input logic [WIN_W-1:0] lit);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 72'(k), 72'(2));
    check({name, "_value"}, out_window, lit);
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 400) begin
      @(negedge clk);
      g++;
    end
    check({name, "_queue_left"}, 72'(exp_q.size()), 72'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, 72'(in_ready), 72'(1));
    check({name, "_out_valid"}, 72'(out_valid), 72'(0));
    check({name, "_out_window"}, out_window, '0);
    check({name, "_line_done"}, 72'(line_done), 72'(0));
  endtask

  // Monitor: pops the scoreboard on each accepted window and tracks line_done placement
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rstn) begin
        exp_q.delete();
        in_line = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("line_done_after_last_window", 72'(line_done), 72'(1));
          pend = 1'b0;
        end else if (line_done) begin
          check("line_done_spurious", 72'(line_done), 72'(0));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_window: got %0h expected none", out_window);
          end else begin
            check("window", out_window, exp_q.pop_front());
          end
          in_line++;
          if (in_line == int'(WPL)) begin
            in_line = 0;
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int g;
    int cnt;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);
    check("reset_release_in_ready", 72'(in_ready), 72'(1));

    // Free-running consumer, seven lines streamed so the read bank wraps
    base = 8'h00;
    for (int r = 0; r < 3; r++) stream_row(r);
    in_valid = 1'b0;
    wait_first("first_window", FIRST_WIN);
    for (int r = 3; r < 7; r++) stream_row(r);
    in_valid = 1'b0;
    wait_drain("drain_stream");

    // Backpressure on the third window of the first line
    do_reset();
    for (int r = 0; r < 3; r++) stream_row(r);
    in_valid = 1'b0;
    g = 0;
    while (!(out_valid && out_window == STALL_WIN) && g < 50) begin
      @(negedge clk);
      g++;
    end
    out_ready = 1'b0;
    check("stall_reached", out_window, STALL_WIN);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 72'(out_valid), 72'(1));
      check("stall_out_window", out_window, STALL_WIN);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_drain("drain_stall");

    // Consumer stalled throughout: buffers fill to four lines
    do_reset();
    out_ready = 1'b0;
    cnt = 0;
    g = 0;
    in_valid = 1'b1;
    in_pixel = pix(0);
    while (in_ready && g < 100) begin
      cnt++;
      if (cnt % int'(LINE_W) == 0 && cnt / int'(LINE_W) >= 3) push_line(cnt / int'(LINE_W) - 3);
      @(negedge clk);
      in_pixel = pix(cnt);
      g++;
    end
    in_valid = 1'b0;
    check("fill_accept_count", 72'(cnt), 72'(32));
    repeat (3) @(negedge clk);
    check("full_in_ready_low", 72'(in_ready), 72'(0));
    out_ready = 1'b1;
    g = 0;
    while (!line_done && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("full_line_done_seen", 72'(line_done), 72'(1));
    check("in_ready_at_line_done", 72'(in_ready), 72'(0));
    @(negedge clk);
    check("in_ready_after_line_done", 72'(in_ready), 72'(1));
    wait_drain("drain_full");

    // Reset in the middle of the third line, then fresh data
    do_reset();
    base = 8'h00;
    stream_row(0);
    stream_row(1);
    for (int c = 0; c < 4; c++) send_pixel(pix(2 * LINE_W + c));
    in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midline_reset");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    base = 8'h80;
    stream_row(0);
    check("no_window_after_1_line", 72'(out_valid), 72'(0));
    stream_row(1);
    check("no_window_after_2_lines", 72'(out_valid), 72'(0));
    for (int c = 0; c < int'(LINE_W) - 1; c++) send_pixel(pix(2 * LINE_W + c));
    check("no_window_after_23_pixels", 72'(out_valid), 72'(0));
    send_pixel(pix(3 * LINE_W - 1));
    push_line(0);
    in_valid = 1'b0;
    wait_first("post_reset_window", POST_WIN);
    wait_drain("drain_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
